// File: rtl/alu_muldiv_controller.sv
// EX-stage ALU control decode plus an iterative multiply/divide sequencer
// with HI/LO registers and a hazard-unit stall output.
module alu_muldiv_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       ALU_operation,
    output logic [1:0]       res_sel,
    output logic             stall,
    output logic             md_busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic             is_rtype, md_op, is_mfhi, is_mflo;
    logic [2:0]       alu_op;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             div_q, div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d, a_q, a_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             start_neg_a, start_neg_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign is_rtype = (ALUop == 2'b10);
    assign md_op    = is_rtype && (func[5:2] == 4'b0110);
    assign is_mfhi  = is_rtype && (func == 6'b010000);
    assign is_mflo  = is_rtype && (func == 6'b010010);

    always_comb begin
        alu_op = 3'b000;
        case (ALUop)
            2'b00: alu_op = 3'b010;
            2'b01: alu_op = 3'b110;
            2'b11: alu_op = 3'b111;
            default: begin
                case (func)
                    6'b100000: alu_op = 3'b010;
                    6'b100010: alu_op = 3'b110;
                    6'b101010: alu_op = 3'b111;
                    6'b100100: alu_op = 3'b000;
                    6'b100101: alu_op = 3'b001;
                    default:   alu_op = 3'b000;
                endcase
            end
        endcase
    end

    assign ALU_operation = alu_op;
    assign res_sel = is_mfhi ? 2'b01 : (is_mflo ? 2'b10 : 2'b00);
    assign md_busy = (state_q != S_IDLE);
    // A waiting md op is released in the IDLE cycle, so stall drops as it starts.
    assign stall   = !rst && md_busy && en && (md_op || is_mfhi || is_mflo);
    assign hi = hi_q;
    assign lo = lo_q;

    // func[0] set means the unsigned variant; signed ops work on magnitudes.
    assign start_neg_a = !func[0] && a[WIDTH-1];
    assign start_neg_b = !func[0] && b[WIDTH-1];

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign prod_fix  = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix   = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
    assign rem_fix   = neg_a_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        div_d    = div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        mag_b_d  = mag_b_q;
        a_d      = a_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (en && md_op) begin
                    state_d  = S_RUN;
                    count_d  = '0;
                    div_d    = func[1];
                    neg_a_d  = start_neg_a;
                    neg_b_d  = start_neg_b;
                    mag_b_d  = start_neg_b ? -b : b;
                    a_d      = a;
                    acc_hi_d = '0;
                    acc_lo_d = start_neg_a ? -a : a;
                end
            end
            S_RUN: begin
                count_d = count_q + 1'b1;
                if (div_q) begin
                    // Restoring step: borrow out of bit WIDTH means the trial subtract failed.
                    acc_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (count_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (mag_b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            div_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mag_b_q  <= '0;
            a_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            div_q    <= div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            mag_b_q  <= mag_b_d;
            a_q      <= a_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end
endmodule
